// File: rtl/guard_recovery_ctrl.sv
// Recovery sequencer for the AXI subordinate guard: holds the subordinate in reset,
// replays the guard config over Regbus, clears the guard irq, then acknowledges the reset.
module guard_recovery_ctrl #(
   parameter int unsigned RegAddrWidth  = 32,
   parameter int unsigned RegDataWidth  = 32,
   parameter int unsigned RstCycles     = 16,
   parameter int unsigned NumCfg        = 2,
   parameter logic [NumCfg-1:0][RegAddrWidth-1:0] CfgAddr = '0,
   parameter logic [NumCfg-1:0][RegDataWidth-1:0] CfgData = '0,
   parameter logic [RegAddrWidth-1:0] IrqClrAddr = '0,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      enable_i,
   input  logic                      rst_req_i,
   input  logic                      irq_i,
   output logic                      sub_rst_no,
   output logic                      rst_stat_o,
   output logic [RegAddrWidth-1:0]   reg_req_addr_o,
   output logic                      reg_req_write_o,
   output logic [RegDataWidth-1:0]   reg_req_wdata_o,
   output logic [RegDataWidth/8-1:0] reg_req_strb_o,
   output logic                      reg_req_valid_o,
   input  logic [RegDataWidth-1:0]   reg_rsp_rdata_i,
   input  logic                      reg_rsp_error_i,
   input  logic                      reg_rsp_ready_i,
   output logic                      busy_o,
   output logic                      err_o,
   output logic [7:0]                recov_cnt_o
);

   localparam int unsigned CntW = (RstCycles > 1) ? $clog2(RstCycles) : 1;
   localparam int unsigned IdxW = (NumCfg > 1) ? $clog2(NumCfg) : 1;
   localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] RstLoad = CntW'(RstCycles - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NumCfg - 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

   typedef enum logic [2:0] {
      IDLE,
      ASSERT_RST,
      CFG,
      CLR_IRQ,
      DONE,
      WAIT_CLR
   } state_e;

   state_e                    state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [TmoW-1:0]           tmo_q, tmo_d;
   logic                      err_q, err_d;
   logic [7:0]                recov_q, recov_d;
   logic                      sub_rst_q, rst_stat_q, busy_q, valid_q;
   logic [RegAddrWidth-1:0]   addr_q, addr_d;
   logic [RegDataWidth-1:0]   wdata_q, wdata_d;

   logic unused_inputs;
   assign unused_inputs = ^{reg_rsp_rdata_i, irq_i};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      recov_d = recov_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i && rst_req_i) begin
               state_d = ASSERT_RST;
               err_d   = 1'b0;
               cnt_d   = RstLoad;
               idx_d   = '0;
            end
         end
         ASSERT_RST: begin
            if (cnt_q == '0) begin
               state_d = CFG;
               tmo_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CFG, CLR_IRQ: begin
            // An error response or a timeout abandons the rest of the replay.
            if (reg_rsp_ready_i) begin
               tmo_d = '0;
               if (reg_rsp_error_i) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (state_q == CLR_IRQ) begin
                  state_d = DONE;
               end else if (idx_q == IdxLast) begin
                  state_d = CLR_IRQ;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (tmo_q == TmoLast) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DONE: begin
            state_d = WAIT_CLR;
            if (!err_q && recov_q != 8'hFF) begin
               recov_d = recov_q + 8'd1;
            end
         end
         WAIT_CLR: begin
            if (!rst_req_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d  = '0;
      wdata_d = '0;
      if (state_d == CFG) begin
         addr_d  = CfgAddr[idx_d];
         wdata_d = CfgData[idx_d];
      end else if (state_d == CLR_IRQ) begin
         addr_d  = IrqClrAddr;
         wdata_d = RegDataWidth'(1);
      end
   end

   // Outputs are registered from the next-state so they line up with the state they describe.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         recov_q    <= '0;
         sub_rst_q  <= 1'b1;
         rst_stat_q <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         recov_q    <= recov_d;
         sub_rst_q  <= (state_d != ASSERT_RST);
         rst_stat_q <= (state_d == DONE);
         busy_q     <= !(state_d inside {IDLE, WAIT_CLR});
         valid_q    <= (state_d inside {CFG, CLR_IRQ});
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign sub_rst_no      = sub_rst_q;
   assign rst_stat_o      = rst_stat_q;
   assign busy_o          = busy_q;
   assign err_o           = err_q;
   assign recov_cnt_o     = recov_q;
   assign reg_req_valid_o = valid_q;
   assign reg_req_write_o = valid_q;
   assign reg_req_addr_o  = addr_q;
   assign reg_req_wdata_o = wdata_q;
   assign reg_req_strb_o  = valid_q ? '1 : '0;

endmodule

// File: tb/tb_guard_recovery_ctrl.sv
// Self-checking bench for guard_recovery_ctrl: builds an expected per-cycle timeline
// of each recovery from the write/wait schedule and compares every output each cycle.
module tb_guard_recovery_ctrl;

   localparam int RstCycles     = 16;
   localparam int TimeoutCycles = 255;
   localparam int MaxCyc        = 600;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        enable_i = 1'b0;
   logic        rst_req_i = 1'b0;
   logic        irq_i = 1'b0;
   logic        sub_rst_no;
   logic        rst_stat_o;
   logic [31:0] reg_req_addr_o;
   logic        reg_req_write_o;
   logic [31:0] reg_req_wdata_o;
   logic [3:0]  reg_req_strb_o;
   logic        reg_req_valid_o;
   logic [31:0] reg_rsp_rdata_i = '0;
   logic        reg_rsp_error_i = 1'b0;
   logic        reg_rsp_ready_i = 1'b0;
   logic        busy_o;
   logic        err_o;
   logic [7:0]  recov_cnt_o;

   int vectors = 0;
   int miscompares = 0;
   int recovCnt = 0;
   int curCyc = 0;

   logic        expSub[MaxCyc];
   logic        expValid[MaxCyc];
   logic [31:0] expAddr[MaxCyc];
   logic [31:0] expData[MaxCyc];
   logic        expStat[MaxCyc];
   logic        expBusy[MaxCyc];
   logic        expErr[MaxCyc];
   int          expCnt[MaxCyc];
   logic        readyIn[MaxCyc];
   logic        errIn[MaxCyc];

   guard_recovery_ctrl #(
      .RegAddrWidth (32),
      .RegDataWidth (32),
      .RstCycles    (RstCycles),
      .NumCfg       (2),
      .CfgAddr      ({32'h14, 32'h10}),
      .CfgData      ({32'd7, 32'd5}),
      .IrqClrAddr   (32'h20),
      .TimeoutCycles(TimeoutCycles)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .enable_i       (enable_i),
      .rst_req_i      (rst_req_i),
      .irq_i          (irq_i),
      .sub_rst_no     (sub_rst_no),
      .rst_stat_o     (rst_stat_o),
      .reg_req_addr_o (reg_req_addr_o),
      .reg_req_write_o(reg_req_write_o),
      .reg_req_wdata_o(reg_req_wdata_o),
      .reg_req_strb_o (reg_req_strb_o),
      .reg_req_valid_o(reg_req_valid_o),
      .reg_rsp_rdata_i(reg_rsp_rdata_i),
      .reg_rsp_error_i(reg_rsp_error_i),
      .reg_rsp_ready_i(reg_rsp_ready_i),
      .busy_o         (busy_o),
      .err_o          (err_o),
      .recov_cnt_o    (recov_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, curCyc, obs, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag, input int cnt);
      checkOutput({tag, "_sub"},   32'(sub_rst_no), 32'd1);
      checkOutput({tag, "_valid"}, 32'(reg_req_valid_o), 32'd0);
      checkOutput({tag, "_stat"},  32'(rst_stat_o), 32'd0);
      checkOutput({tag, "_busy"},  32'(busy_o), 32'd0);
      checkOutput({tag, "_cnt"},   32'(recov_cnt_o), 32'(cnt));
   endtask

   // Writes in order: cfg0, cfg1, irq clear. errIdx/toIdx select a write that errors or times out (-1 = none).
   task automatic applyStimulus(input int w0, input int w1, input int w2,
                                input int errIdx, input int toIdx,
                                input int dropCyc, input bit hold);
      int          waits[3];
      logic [31:0] wAddr[3];
      logic [31:0] wData[3];
      int          t, done, dropAt, lastCyc, w;
      bit          errored;
      int          cntAfter;
      waits = '{w0, w1, w2};
      wAddr = '{32'h10, 32'h14, 32'h20};
      wData = '{32'd5, 32'd7, 32'd1};
      for (int n = 0; n < MaxCyc; n++) begin
         expSub[n] = 1'b1; expValid[n] = 1'b0; expAddr[n] = '0; expData[n] = '0;
         expStat[n] = 1'b0; expBusy[n] = 1'b0;
         readyIn[n] = 1'($urandom_range(0, 1));
         errIn[n]   = 1'($urandom_range(0, 1));
      end
      for (int n = 1; n <= RstCycles; n++) begin
         expSub[n] = 1'b0; expBusy[n] = 1'b1;
      end
      t = RstCycles + 1;
      errored = 1'b0;
      for (int k = 0; k < 3 && !errored; k++) begin
         w = (k == toIdx) ? TimeoutCycles : waits[k];
         for (int j = 0; j <= w; j++) begin
            if (j == w && k == toIdx) break;
            expValid[t+j] = 1'b1; expBusy[t+j] = 1'b1;
            expAddr[t+j] = wAddr[k]; expData[t+j] = wData[k];
            readyIn[t+j] = (j == w);
            errIn[t+j]   = (j == w) ? (k == errIdx) : errIn[t+j];
         end
         if (k == toIdx) begin
            errored = 1'b1;
            t = t + w;
         end else begin
            t = t + w + 1;
            if (k == errIdx) errored = 1'b1;
         end
      end
      done = t;
      expStat[done] = 1'b1;
      expBusy[done] = 1'b1;
      cntAfter = errored ? recovCnt : ((recovCnt >= 255) ? 255 : recovCnt + 1);
      if (dropCyc != 0) dropAt = dropCyc;
      else if (hold) dropAt = done + 10 + int'($urandom_range(0, 8));
      else dropAt = done + 1 + int'($urandom_range(0, 4));
      lastCyc = dropAt + 3;
      for (int n = 0; n < MaxCyc; n++) begin
         expErr[n] = errored && (n >= done);
         expCnt[n] = (n <= done) ? recovCnt : cntAfter;
      end

      rst_req_i = 1'b1;
      enable_i  = 1'b1;
      for (int n = 1; n <= lastCyc; n++) begin
         @(posedge clk_i);
         #1;
         curCyc = n;
         reg_rsp_ready_i = readyIn[n];
         reg_rsp_error_i = errIn[n];
         rst_req_i = (n < dropAt);
         enable_i  = 1'($urandom_range(0, 1));
         irq_i     = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         checkOutput("sub_rst",  32'(sub_rst_no), 32'(expSub[n]));
         checkOutput("valid",    32'(reg_req_valid_o), 32'(expValid[n]));
         checkOutput("write",    32'(reg_req_write_o), 32'(expValid[n]));
         checkOutput("strb",     32'(reg_req_strb_o), expValid[n] ? 32'hF : 32'h0);
         if (expValid[n]) begin
            checkOutput("addr",  reg_req_addr_o, expAddr[n]);
            checkOutput("wdata", reg_req_wdata_o, expData[n]);
         end
         checkOutput("rst_stat", 32'(rst_stat_o), 32'(expStat[n]));
         checkOutput("busy",     32'(busy_o), 32'(expBusy[n]));
         checkOutput("err",      32'(err_o), 32'(expErr[n]));
         checkOutput("recov_cnt", 32'(recov_cnt_o), 32'(expCnt[n]));
      end
      recovCnt = cntAfter;
      reg_rsp_ready_i = 1'b0;
      reg_rsp_error_i = 1'b0;
   endtask

   initial begin
      int eIdx;
      #12;
      curCyc = 0;
      checkIdleOutputs("reset", 0);
      checkOutput("reset_err",  32'(err_o), 32'd0);
      checkOutput("reset_addr", reg_req_addr_o, 32'd0);
      checkOutput("reset_strb", 32'(reg_req_strb_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("[TB] nominal recovery");
      applyStimulus(0, 0, 0, -1, -1, 25, 1'b0);
      $display("[TB] backpressure on first write");
      applyStimulus(3, 0, 0, -1, -1, 0, 1'b0);
      $display("[TB] error response on second config write");
      applyStimulus(0, 0, 0, 1, -1, 0, 1'b0);
      $display("[TB] clean recovery clears sticky error");
      applyStimulus(0, 0, 0, -1, -1, 0, 1'b0);

      $display("[TB] randomized recoveries");
      for (int r = 0; r < 10; r++) begin
         eIdx = int'($urandom_range(0, 6));
         if (eIdx > 2) eIdx = -1;
         applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)), eIdx, -1, 0, 1'($urandom_range(0, 1)));
      end

      $display("[TB] timeout on first write");
      applyStimulus(0, 0, 0, -1, 0, 0, 1'b0);
      $display("[TB] stale request held through done");
      applyStimulus(1, 0, 2, -1, -1, 0, 1'b1);

      $display("[TB] request ignored while disabled");
      rst_req_i = 1'b1;
      enable_i  = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk_i);
         #1;
         curCyc = n;
         irq_i = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         checkIdleOutputs("disabled", recovCnt);
      end
      rst_req_i = 1'b0;
      @(negedge clk_i);

      $display("[TB] async reset mid-sequence");
      rst_req_i = 1'b1;
      enable_i  = 1'b1;
      @(posedge clk_i);
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk_i);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      curCyc = 8;
      checkIdleOutputs("async_rst", 0);
      checkOutput("async_rst_err", 32'(err_o), 32'd0);
      recovCnt = 0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      applyStimulus(0, 0, 0, -1, -1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
